// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared CPU constants, fetch FSM states and the FIFO entry type.
package fetch_unit_pkg;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          OPC_W            = 7;
   localparam logic [6:0]  OPC_OP_IMM       = 7'b0010011;
   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST         = {25'd0, OPC_OP_IMM};

   typedef enum logic {
      RUN,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] inst);
      return inst[OPC_W-1:0];
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry {pc, inst} queue, entry 0 is always the head.
// Shows a NOP at pc 0 while empty.
module fetch_fifo
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t din,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);
   localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'd0, inst: NOP_INST};

   fetch_entry_t e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d, n;

   // Pop first, then push into the first free slot; this lets push and pop share a cycle at count 2.
   always_comb begin
      n     = cnt_q - {1'b0, pop && cnt_q != 2'd0};
      e0_d  = (pop && cnt_q != 2'd0) ? e1_q : e0_q;
      e1_d  = e1_q;
      if (push && n == 2'd0) e0_d = din;
      if (push && n == 2'd1) e1_d = din;
      cnt_d = flush ? 2'd0 : n + {1'b0, push && n != 2'd2};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0_q  <= EMPTY_ENTRY;
         e1_q  <= EMPTY_ENTRY;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign empty = cnt_q == 2'd0;
   assign full  = cnt_q == 2'd2;
   assign count = cnt_q;
   assign head  = empty ? EMPTY_ENTRY : e0_q;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with 2-deep decode buffer, redirect and response drain.
// Define FETCH_PERF_EN to add the fetch_stall_cnt performance counter.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        im_req,
   output logic [31:0] im_addr,
   input  logic        im_ready,
   input  logic        im_rvalid,
   input  logic [31:0] im_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        id_valid,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [6:0]  id_opcode
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_stall_cnt
`endif
);
   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [1:0]   out_q, out_d, drop_q, drop_d, slot;
   logic [31:0]  ifq0_q, ifq0_d, ifq1_q, ifq1_d;
   logic         acc, rv, push, pop;
   logic [1:0]   fifo_cnt;
   logic         fifo_full, fifo_empty;
   fetch_entry_t head, din;

   always_comb begin
      im_req   = !rst && state_q == RUN && !redirect_valid && !fifo_full &&
                 (3'(out_q) + 3'(fifo_cnt) < 3'd2);
      im_addr  = pc_q;
      acc      = im_req && im_ready;
      rv       = im_rvalid && out_q != 2'd0;
      push     = rv && state_q == RUN && !redirect_valid;
      pop      = id_valid && id_ready && !redirect_valid;
      din.pc   = ifq0_q;
      din.inst = im_rdata;
      out_d    = out_q + 2'(acc) - 2'(rv);
      // In-flight PCs retire in order; the returning response frees the head before the new PC lands.
      slot     = out_q - 2'(rv);
      ifq0_d   = rv ? ifq1_q : ifq0_q;
      ifq1_d   = ifq1_q;
      if (acc && slot == 2'd0) ifq0_d = pc_q;
      if (acc && slot == 2'd1) ifq1_d = pc_q;
      pc_d     = redirect_valid ? (redirect_pc & ~32'd3) : acc ? pc_q + 32'd4 : pc_q;
      state_d  = state_q;
      drop_d   = drop_q;
      if (redirect_valid) begin
         drop_d  = out_d;
         state_d = out_d != 2'd0 ? DRAIN : RUN;
      end else if (state_q == DRAIN && rv) begin
         drop_d  = drop_q - 2'd1;
         state_d = drop_q == 2'd1 ? RUN : DRAIN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC & ~32'd3;
         out_q   <= 2'd0;
         drop_q  <= 2'd0;
         ifq0_q  <= 32'd0;
         ifq1_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         ifq0_q  <= ifq0_d;
         ifq1_q  <= ifq1_d;
      end
   end

   fetch_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (push),
      .pop   (pop),
      .din   (din),
      .head  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_cnt)
   );

   assign id_valid  = !fifo_empty;
   assign id_pc     = head.pc;
   assign id_inst   = head.inst;
   assign id_opcode = opcode_of(head.inst);

`ifdef FETCH_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb stall_d = (id_ready && !id_valid && stall_q != '1) ? stall_q + 32'd1 : stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_q <= 32'd0;
      else     stall_q <= stall_d;
   end

   assign fetch_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch_unit bench against an in-order memory and a PC-stream model.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        im_req, im_ready, im_rvalid, redirect_valid, id_ready, id_valid;
   logic [31:0] im_addr, im_rdata, redirect_pc, id_inst, id_pc;
   logic [6:0]  id_opcode;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_stall_cnt;
`endif

   fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .im_req         (im_req),
      .im_addr        (im_addr),
      .im_ready       (im_ready),
      .im_rvalid      (im_rvalid),
      .im_rdata       (im_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .id_valid       (id_valid),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_opcode      (id_opcode)
`ifdef FETCH_PERF_EN
      ,
      .fetch_stall_cnt(fetch_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } rsp_t;

   rsp_t        mq[$];
   logic [31:0] acc_log[$];
   int          total = 0, bad = 0, cyc = 0, last_due = 0, lat_lo = 1, lat_hi = 1;
   int          drop_left = 0, n_acc = 0, n_pop = 0, first_acc = -1, first_valid = -1;
   logic [31:0] exp_addr = 0, exp_id_pc = 0, last_pop_pc = 0, prev_pc = 0, prev_inst = 0;
   logic        prev_hold = 0, s_im_req = 0, s_id_valid = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
   endfunction

   task automatic clear_model();
      mq.delete();
      acc_log.delete();
      drop_left   = 0;
      exp_addr    = 0;
      exp_id_pc   = 0;
      prev_hold   = 0;
      last_due    = cyc;
      first_acc   = -1;
      first_valid = -1;
   endtask

   // One clock: drive at posedge+1, sample at the falling edge, update the model, advance.
   task automatic cycle(input logic redir, input logic [31:0] tgt, input logic rdy, input logic idr);
      logic rv, acc, pop;
      logic [31:0] w;
      int d;
      redirect_valid = redir;
      redirect_pc    = tgt;
      im_ready       = rdy;
      id_ready       = idr;
      rv             = mq.size() > 0 && mq[0].due <= cyc;
      im_rvalid      = rv;
      im_rdata       = rv ? mem_word(mq[0].addr) : $urandom;
      #4;
      acc        = im_req && rdy;
      pop        = id_valid && idr;
      s_im_req   = im_req;
      s_id_valid = id_valid;
      if (id_valid && first_valid < 0) first_valid = cyc;
      if (prev_hold) begin
         total++;
         if (id_valid !== 1'b1 || id_pc !== prev_pc || id_inst !== prev_inst) begin
            bad++;
            $display("FAIL hold: valid=%b pc=%h inst=%h, required valid=1 pc=%h inst=%h",
                     id_valid, id_pc, id_inst, prev_pc, prev_inst);
         end
      end
      if (redir || drop_left > 0) begin
         total++;
         if (im_req !== 1'b0) begin
            bad++;
            $display("FAIL req_blocked: im_req=%b required 0 (redir=%b drop_left=%0d)", im_req, redir, drop_left);
         end
      end
      if (acc) begin
         total++;
         if (im_addr !== exp_addr) begin
            bad++;
            $display("FAIL im_addr: got %h required %h", im_addr, exp_addr);
         end
         acc_log.push_back(im_addr);
         if (first_acc < 0) first_acc = cyc;
         n_acc++;
         d        = cyc + int'($urandom_range(lat_hi, lat_lo));
         last_due = d > last_due ? d : last_due + 1;
         mq.push_back('{addr: im_addr, due: last_due});
         exp_addr = exp_addr + 32'd4;
      end
      if (pop && !redir) begin
         w = mem_word(exp_id_pc);
         total++;
         if (id_pc !== exp_id_pc || id_inst !== w || id_opcode !== w[6:0]) begin
            bad++;
            $display("FAIL pop: pc=%h inst=%h op=%h, required pc=%h inst=%h op=%h",
                     id_pc, id_inst, id_opcode, exp_id_pc, w, w[6:0]);
         end
         last_pop_pc = id_pc;
         n_pop++;
         exp_id_pc = exp_id_pc + 32'd4;
      end
      if (rv) begin
         void'(mq.pop_front());
         if (drop_left > 0) drop_left--;
      end
      if (redir) begin
         drop_left = mq.size();
         exp_addr  = tgt;
         exp_id_pc = tgt;
      end
      prev_hold = id_valid && !idr && !redir;
      prev_pc   = id_pc;
      prev_inst = id_inst;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1; redirect_valid = 0; redirect_pc = 0; im_ready = 0; im_rvalid = 0; im_rdata = 0; id_ready = 0;
      #12;
      total++; if (im_req !== 1'b0) begin bad++; $display("FAIL rst_im_req: got %b required 0", im_req); end
      total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL rst_id_valid: got %b required 0", id_valid); end
      total++; if (id_inst !== 32'h0000_0013) begin bad++; $display("FAIL rst_id_inst: got %h required 00000013", id_inst); end
      total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL rst_id_pc: got %h required 0", id_pc); end
      total++; if (id_opcode !== 7'b0010011) begin bad++; $display("FAIL rst_opcode: got %b required 0010011", id_opcode); end
      @(posedge clk); #1;
      rst = 0;
      clear_model();
      #1;
      total++;
      if (im_req !== 1'b1 || im_addr !== 32'h0) begin
         bad++;
         $display("FAIL first_req: im_req=%b addr=%h required 1 / 00000000", im_req, im_addr);
      end
      @(posedge clk); #1;
      cyc++;
      clear_model();
   endtask

   task automatic test_basic();
      lat_lo = 1; lat_hi = 1;
      for (int k = 0; k < 8; k++) cycle(0, 0, 1, 1);
      total++;
      if (acc_log.size() < 3 || acc_log[0] !== 32'h0 || acc_log[1] !== 32'h4 || acc_log[2] !== 32'h8) begin
         bad++;
         $display("FAIL basic_addrs: got %0d accepts, required 0,4,8 first", acc_log.size());
      end
      total++;
      if (first_valid - first_acc != 2) begin
         bad++;
         $display("FAIL basic_latency: id_valid %0d cycles after accept, required 2", first_valid - first_acc);
      end
   endtask

   task automatic test_stall();
      int p0;
      for (int k = 0; k < 10; k++) cycle(0, 0, 1, 0);
      total++; if (s_im_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b required 0", s_im_req); end
      total++; if (s_id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b required 1", s_id_valid); end
      p0 = n_pop;
      for (int k = 0; k < 6; k++) cycle(0, 0, 0, 1);
      total++; if (n_pop - p0 != 2) begin bad++; $display("FAIL stall_drain: popped %0d required 2", n_pop - p0); end
      total++; if (s_id_valid !== 1'b0) begin bad++; $display("FAIL stall_empty: id_valid=%b required 0", s_id_valid); end
   endtask

   task automatic test_redirect();
      int a0, p0;
      lat_lo = 4; lat_hi = 4;
      for (int k = 0; k < 40 && !(mq.size() == 2 && mq[0].due > cyc); k++) cycle(0, 0, 1, 1);
      total++;
      if (!(mq.size() == 2 && mq[0].due > cyc)) begin bad++; $display("FAIL redir_setup: timeout, outstanding=%0d required 2", mq.size()); end
      cycle(1, 32'h100, 1, 1);
      a0 = acc_log.size();
      for (int k = 0; k < 40 && acc_log.size() == a0; k++) cycle(0, 0, 1, 1);
      total++;
      if (acc_log.size() == a0 || acc_log[a0] !== 32'h100) begin
         bad++;
         $display("FAIL redir_addr: accepts=%0d first=%h required 00000100", acc_log.size() - a0,
                  acc_log.size() > a0 ? acc_log[a0] : 32'hx);
      end
      p0 = n_pop;
      for (int k = 0; k < 40 && n_pop == p0; k++) cycle(0, 0, 1, 1);
      total++;
      if (n_pop == p0 || last_pop_pc !== 32'h100) begin
         bad++;
         $display("FAIL redir_pc: pops=%0d pc=%h required 00000100", n_pop - p0, last_pop_pc);
      end
   endtask

   task automatic test_collide();
      int p0;
      lat_lo = 2; lat_hi = 2;
      for (int k = 0; k < 60 && !(id_valid === 1'b1 && mq.size() > 0 && mq[0].due <= cyc); k++) cycle(0, 0, 1, 1);
      total++;
      if (!(id_valid === 1'b1 && mq.size() > 0 && mq[0].due <= cyc)) begin bad++; $display("FAIL collide_setup: timeout, id_valid=%b", id_valid); end
      cycle(1, 32'h200, 1, 1);
      cycle(0, 0, 0, 1);
      total++; if (s_id_valid !== 1'b0) begin bad++; $display("FAIL collide_flush: id_valid=%b required 0", s_id_valid); end
      p0 = n_pop;
      for (int k = 0; k < 40 && n_pop == p0; k++) cycle(0, 0, 1, 1);
      total++;
      if (n_pop == p0 || last_pop_pc !== 32'h200) begin
         bad++;
         $display("FAIL collide_resume: pops=%0d pc=%h required 00000200", n_pop - p0, last_pop_pc);
      end
   endtask

   task automatic test_wrap();
      int a0, p0;
      lat_lo = 1; lat_hi = 1;
      cycle(1, 32'hFFFF_FFFC, 1, 1);
      a0 = acc_log.size();
      p0 = n_pop;
      for (int k = 0; k < 40 && (acc_log.size() < a0 + 2 || n_pop < p0 + 2); k++) cycle(0, 0, 1, 1);
      total++;
      if (acc_log.size() < a0 + 2 || acc_log[a0] !== 32'hFFFF_FFFC || acc_log[a0+1] !== 32'h0) begin
         bad++;
         $display("FAIL wrap_addr: accepts=%0d, required FFFFFFFC then 00000000", acc_log.size() - a0);
      end
      total++;
      if (n_pop < p0 + 2) begin bad++; $display("FAIL wrap_pop: pops=%0d required 2", n_pop - p0); end
   endtask

   task automatic test_reset_mid();
      lat_lo = 3; lat_hi = 3;
      for (int k = 0; k < 20 && mq.size() == 0; k++) cycle(0, 0, 1, 1);
      cycle(0, 0, 1, 1);
      #2;
      rst = 1;
      #1;
      total++;
      if (im_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin
         bad++;
         $display("FAIL midrst: im_req=%b id_valid=%b id_pc=%h required 0/0/0", im_req, id_valid, id_pc);
      end
      @(posedge clk); #1;
      cyc++;
      rst = 0;
      clear_model();
      cycle(0, 0, 1, 1);
      total++;
      if (acc_log.size() != 1 || acc_log[0] !== 32'h0) begin
         bad++;
         $display("FAIL midrst_req: accepts=%0d required 1 at 00000000", acc_log.size());
      end
   endtask

   task automatic test_random();
      int p0;
      logic r;
      p0 = n_pop;
      lat_lo = 1; lat_hi = 3;
      for (int k = 0; k < 3000; k++) begin
         r = $urandom_range(99, 0) < 3;
         cycle(r, $urandom & 32'hFFFF_FFFC, $urandom_range(99, 0) < 75, $urandom_range(99, 0) < 70);
      end
      total++;
      if (n_pop - p0 < 200) begin bad++; $display("FAIL random_progress: pops=%0d required >=200", n_pop - p0); end
   endtask

`ifdef FETCH_PERF_EN
   task automatic test_perf();
      rst = 1; redirect_valid = 0; im_ready = 0; im_rvalid = 0; id_ready = 1;
      @(posedge clk); #1;
      rst = 0;
      repeat (5) @(posedge clk);
      #1;
      total++;
      if (fetch_stall_cnt !== 32'd5) begin bad++; $display("FAIL perf_cnt: got %0d required 5", fetch_stall_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_redirect();
      test_collide();
      test_wrap();
      test_reset_mid();
      test_random();
`ifdef FETCH_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
